// File: rtl/pat_det_pkg.sv
// ============================================================================
// pat_det_pkg : shared types, default constants and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package pat_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int         DEF_FRAME_W = 8;
    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PAT     = 4'b1011;

    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pat_det_core.sv
// ============================================================================
// pat_det_core : serial pattern history, compare and overlapping match count
// Rev 1.0
// ============================================================================
`default_nettype none

module pat_det_core
    import pat_det_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int PAT_W   = DEF_PAT_W,
    parameter int CW      = cnt_width(FRAME_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    bits_seen
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] next_hist;
    logic             match;

    assign next_hist = {hist[PAT_W-2:0], bit_in};
    // bits_seen is the count before this bit, so a full window needs PAT_W-1 prior bits
    assign match     = (next_hist == pattern) && (bits_seen >= CW'(PAT_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist      <= '0;
            count     <= '0;
            bits_seen <= '0;
        end else if (clr) begin
            hist      <= '0;
            count     <= '0;
            bits_seen <= '0;
        end else if (bit_en) begin
            hist      <= next_hist;
            bits_seen <= bits_seen + 1'b1;
            if (match)
                count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pat_det_sched.sv
// ============================================================================
// pat_det_sched : round-robin scheduler sharing one serial pattern detector
// Optional macro PAT_PROG_EN adds a runtime-programmable pattern (cfg_we/cfg_pat)
// Rev 1.0
// ============================================================================
`default_nettype none

module pat_det_sched
    import pat_det_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               FRAME_W = DEF_FRAME_W,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT     = PAT_W'(DEF_PAT),
    parameter int               ID_W    = $clog2(NUM_REQ),
    parameter int               CW      = cnt_width(FRAME_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic [CW-1:0]              res_count,
    output logic                       res_hit,
    output logic                       busy
`ifdef PAT_PROG_EN
    ,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pat
`endif
);

    state_t             state;
    state_t             state_d;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    cur_id;
    logic [FRAME_W-1:0] frame;
    logic [PAT_W-1:0]   pattern;
    logic [CW-1:0]      core_count;
    logic [CW-1:0]      bits_seen;
    logic               core_clr;
    logic               bit_en;
    logic               grant;
    logic               found;
    int                 win;
    int                 idx;

`ifdef PAT_PROG_EN
    logic [PAT_W-1:0] pat_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pat_reg <= PAT;
        else if (state == IDLE && cfg_we)
            pat_reg <= cfg_pat;
    end

    assign pattern = pat_reg;
`else
    assign pattern = PAT;
`endif

    always_comb begin
        state_d   = state;
        found     = 1'b0;
        win       = 0;
        idx       = 0;
        grant     = 1'b0;
        req_ready = '0;
        core_clr  = 1'b0;
        bit_en    = 1'b0;

        // first valid requester after the last winner, wrapping around
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        case (state)
            IDLE: begin
                if (found && rst) begin
                    grant     = 1'b1;
                    req_ready = NUM_REQ'(1) << win;
                    core_clr  = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bit_en = 1'b1;
                if (bits_seen == CW'(FRAME_W - 1))
                    state_d = REPORT;
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= ID_W'(NUM_REQ - 1);
            cur_id    <= '0;
            frame     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_count <= '0;
            res_hit   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy      <= (state_d != IDLE);
            res_valid <= (state == REPORT);
            if (state == REPORT) begin
                res_id    <= cur_id;
                res_count <= core_count;
                res_hit   <= (core_count != '0);
            end
            if (grant) begin
                frame  <= req_data[win*FRAME_W +: FRAME_W];
                cur_id <= ID_W'(win);
                ptr    <= ID_W'(win);
            end else if (state == SHIFT) begin
                frame <= {frame[FRAME_W-2:0], 1'b0};
            end
        end
    end

    pat_det_core #(
        .FRAME_W (FRAME_W),
        .PAT_W   (PAT_W),
        .CW      (CW)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clr       (core_clr),
        .bit_en    (bit_en),
        .bit_in    (frame[FRAME_W-1]),
        .pattern   (pattern),
        .count     (core_count),
        .bits_seen (bits_seen)
    );

endmodule

`default_nettype wire

// File: tb/tb_pat_det_sched.sv
// ============================================================================
// tb_pat_det_sched : directed and randomized bench for pat_det_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pat_det_sched;

    localparam int         N  = 4;
    localparam int         FW = 8;
    localparam int         PW = 4;
    localparam int         IW = 2;
    localparam int         CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*FW-1:0]   req_data  = '0;
    logic [N-1:0]      req_ready;
    logic              res_valid;
    logic [IW-1:0]     res_id;
    logic [CW-1:0]     res_count;
    logic              res_hit;
    logic              busy;
`ifdef PAT_PROG_EN
    logic              cfg_we  = 1'b0;
    logic [PW-1:0]     cfg_pat = '0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ptr      = N - 1;
    bit chk_on   = 1'b0;
    logic [PW-1:0] cur_pat = 4'b1011;

    pat_det_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_count (res_count),
        .res_hit   (res_hit),
        .busy      (busy)
`ifdef PAT_PROG_EN
        ,
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // count of PW-wide windows of the frame equal to the pattern, read MSB-first
    function automatic int ref_count(input logic [FW-1:0] f, input logic [PW-1:0] p);
        int c = 0;
        logic [FW-1:0] t;
        for (int s = 0; s <= FW - PW; s++) begin
            t = f >> (FW - PW - s);
            if (t[PW-1:0] == p) c++;
        end
        return c;
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            if (busy) check("ready_while_busy", 32'(req_ready), 0);
        end
    end

    // called #1 after a rising edge with the DUT idle; returns cycle of grant
    task automatic txn(input logic [N-1:0] v, input bit hold, input bit cfg_in_shift, output int gcyc);
        int w, n, k, exp_c;
        logic [FW-1:0] f;
        w = pick(v);
        req_valid = v;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            @(posedge clk); #2; n++;
        end
        check("grant_timeout", 32'(n < 40), 1);
        check("grant_sel", 32'(req_ready), 32'(N'(1) << w));
        f = req_data[w*FW +: FW];
        gcyc = cyc;
        @(posedge clk);
        ptr = w;
        #1;
`ifdef PAT_PROG_EN
        cfg_we = 1'b0;
`endif
        if (!hold) req_valid = '0;
        check("busy_shift", 32'(busy), 1);
        k = 0;
        while (!res_valid && k < 30) begin
`ifdef PAT_PROG_EN
            if (cfg_in_shift && k == 3) begin
                cfg_we  = 1'b1;
                cfg_pat = '0;
            end
`endif
            @(posedge clk); #1; k++;
`ifdef PAT_PROG_EN
            cfg_we = 1'b0;
`endif
        end
        exp_c = ref_count(f, cur_pat);
        check("latency", 32'(k), FW + 1);
        check("res_id", 32'(res_id), 32'(w));
        check("res_count", 32'(res_count), 32'(exp_c));
        check("res_hit", 32'(res_hit), 32'(exp_c != 0));
        check("busy_after", 32'(busy), 0);
    endtask

    initial begin
        int g, prev_g;
        bit rv_seen;
        logic [N-1:0] v;

        // reset held with all requesters valid
        req_valid = 4'b1111;
        req_data  = {8'h5A, 8'h3C, 8'hB6, 8'hBB};
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_res_count", 32'(res_count), 0);
        check("rst_res_hit", 32'(res_hit), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk_on = 1'b1;

        // basic match, req 0 wins first
        txn(4'b1111, 0, 0, g);

        // overlap and miss on req 1
        req_data[1*FW +: FW] = 8'b1011_0110;
        txn(4'b0010, 0, 0, g);
        req_data[1*FW +: FW] = 8'h00;
        txn(4'b0010, 0, 0, g);
        req_data[3*FW +: FW] = 8'hD6;
        txn(4'b1000, 0, 0, g);

        // fairness with everyone valid: 0,1,2,3,0
        req_data = {8'hDB, 8'h2D, 8'hB6, 8'hBB};
        txn(4'b1111, 1, 0, prev_g);
        for (int i = 0; i < 4; i++) begin
            txn(4'b1111, 1, 0, g);
            check("grant_spacing", 32'(g - prev_g), FW + 2);
            prev_g = g;
        end
        req_valid = '0;
        @(posedge clk); #1;

        // reset in the 4th shift cycle
        req_data[2*FW +: FW] = 8'hBB;
        req_valid = 4'b0100;
        #1;
        check("mid_grant", 32'(req_ready), 32'(4'b0100));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_res_valid", 32'(res_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ptr = N - 1;
        rv_seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (res_valid) rv_seen = 1'b1;
        end
        check("mid_no_result", 32'(rv_seen), 0);
        txn(4'b1111, 0, 0, g);

        // randomized traffic
        for (int i = 0; i < 20; i++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) req_data[r*FW +: FW] = FW'($urandom);
            txn(v, 0, 0, g);
        end

`ifdef PAT_PROG_EN
        cfg_we  = 1'b1;
        cfg_pat = 4'b1111;
        @(posedge clk); #1;
        cfg_we  = 1'b0;
        cur_pat = 4'b1111;
        req_data[0 +: FW] = 8'hFF;
        txn(4'b0001, 0, 1, g);
        txn(4'b0001, 0, 0, g);
        // load in the same cycle as the grant
        cfg_we  = 1'b1;
        cfg_pat = 4'b0000;
        cur_pat = 4'b0000;
        req_data[0 +: FW] = 8'h00;
        txn(4'b0001, 0, 0, g);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
